// File: rtl/mem_burst_handshake.sv
// Single-port burst memory: valid/ready command handshake, strobed write beats,
// and read beats with one-cycle latency and rready backpressure.
module mem_burst_handshake #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [WIDTH/8-1:0]    wstrb_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rlast_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int NBYTES = int'(WIDTH / 8);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [WIDTH-1:0]      r_rdata;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_addr_ok;
    logic                  w_wbeat;
    logic                  w_rbeat;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    // Incrementing address that wraps at DEPTH-1, so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (32'(a) == DEPTH - 1) return '0;
        return a + ADDR_WIDTH'(1);
    endfunction

    assign w_accept    = valid_i && (r_state == S_IDLE);
    assign w_addr_ok   = 32'(addr_i) < DEPTH;
    assign w_wbeat     = (r_state == S_WRITE) && wvalid_i;
    assign w_rbeat     = (r_state == S_READ) && r_rvalid && rready_i;
    assign w_next_addr = f_next_addr(r_cur_addr);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        ready_o      = 1'b0;
        wready_o     = 1'b0;
        busy_o       = 1'b1;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
                if (valid_i && w_addr_ok)
                    w_next_state = wr_rd_en_i ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                wready_o = 1'b1;
                if (wvalid_i && (r_cnt == '0)) w_next_state = S_IDLE;
            end
            S_READ: begin
                if (w_rbeat && r_rlast) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_cur_addr <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_accept && !w_addr_ok;
            if (w_accept && w_addr_ok) begin
                r_cur_addr <= addr_i;
                r_cnt      <= len_i;
                // Reads prefetch the first beat at accept time for one-cycle latency.
                if (!wr_rd_en_i) begin
                    r_rdata  <= r_mem[addr_i];
                    r_rvalid <= 1'b1;
                    r_rlast  <= (len_i == '0);
                end
            end
            if (w_wbeat) begin
                for (int k = 0; k < NBYTES; k++)
                    if (wstrb_i[k]) r_mem[r_cur_addr][8*k +: 8] <= wdata_i[8*k +: 8];
                r_cur_addr <= w_next_addr;
                r_cnt      <= r_cnt - LEN_WIDTH'(1);
            end
            if (w_rbeat) begin
                if (r_rlast) begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                end else begin
                    r_cur_addr <= w_next_addr;
                    r_rdata    <= r_mem[w_next_addr];
                    r_rlast    <= (r_cnt == LEN_WIDTH'(1));
                    r_cnt      <= r_cnt - LEN_WIDTH'(1);
                end
            end
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign rlast_o  = r_rlast;
    assign err_o    = r_err;

endmodule
